axis_pkt_arbiter: RTL and testbench

Packet-level round-robin arbiter that shares one AXI-Stream output between NUM_SRC AXI-Stream inputs. A grant is held for a whole packet, from the first accepted beat through the beat with tlast, so packets are never interleaved. It sits upstream of any single-port stream consumer (DMA write path, packet FIFO, framer) that several producers feed. Output beats pass through one registered stage.

---
 rtl/axis_arb_pkg.sv | 16 +
 rtl/axis_rr_pick.sv | 42 ++++
 rtl/axis_pkt_arbiter.sv | 139 +++++++++++++
 tb/tb_axis_pkt_arbiter.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_arb_pkg.sv
// Shared types and helpers for the packet arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package axis_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Width of a source index; never narrower than one bit.
    function automatic int src_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Round-robin picker: first set request at or after ptr, wrapping upward.
// Latency: purely combinational.
// Backpressure: none; it only looks at the request vector.
module axis_rr_pick
    import axis_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int SRC_W   = src_width(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   ptr,
    output logic [SRC_W-1:0]   idx,
    output logic               any
);

    // Requests rotated so that bit 0 corresponds to the source at ptr.
    logic [2*NUM_SRC-1:0] w_dbl;
    logic [NUM_SRC-1:0]   w_rot;

    assign w_dbl = {req, req} >> ptr;
    assign w_rot = w_dbl[NUM_SRC-1:0];

    // Lowest rotated offset wins; offset is then mapped back to a source index.
    always_comb begin
        int off;
        int sum;
        off = 0;
        sum = 0;
        any = |w_rot;
        for (int k = NUM_SRC - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                off = k;
            end
        end
        sum = int'(ptr) + off;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        idx = SRC_W'(sum);
    end

endmodule

// File: rtl/axis_pkt_arbiter.sv
// Packet-level round-robin arbiter, NUM_SRC AXI-Stream inputs onto one output.
// Latency: 1 cycle arbitration in IDLE, then 1 cycle input-to-output per beat.
// Backpressure: granted s_tready drops combinationally when the output is full and m_tready is low.
module axis_pkt_arbiter
    import axis_arb_pkg::*;
#(
    parameter  int NUM_SRC   = 4,
    parameter  int DATA_SIZE = 32,
    parameter  int USER_SIZE = 16,
    localparam int SRC_W     = src_width(NUM_SRC),
    localparam int KEEP_W    = DATA_SIZE / 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC-1:0]            s_tlast,
    input  logic [NUM_SRC*DATA_SIZE-1:0]  s_tdata,
    input  logic [NUM_SRC*KEEP_W-1:0]     s_tkeep,
    input  logic [NUM_SRC*USER_SIZE-1:0]  s_tuser,
    output logic                          m_tvalid,
    output logic                          m_tlast,
    input  logic                          m_tready,
    output logic [DATA_SIZE-1:0]          m_tdata,
    output logic [KEEP_W-1:0]             m_tkeep,
    output logic [USER_SIZE-1:0]          m_tuser,
    output logic [SRC_W-1:0]              m_tid,
    output logic                          busy
);

    arb_state_t             r_state;
    logic [SRC_W-1:0]       r_grant_idx;
    logic [SRC_W-1:0]       r_rr_ptr;
    logic                   r_m_tvalid;
    logic                   r_m_tlast;
    logic [DATA_SIZE-1:0]   r_m_tdata;
    logic [KEEP_W-1:0]      r_m_tkeep;
    logic [USER_SIZE-1:0]   r_m_tuser;
    logic [SRC_W-1:0]       r_m_tid;

    logic [SRC_W-1:0]       w_pick_idx;
    logic                   w_pick_any;
    logic [NUM_SRC-1:0]     w_s_tready;
    logic                   w_accept;
    logic                   w_sel_last;
    logic [DATA_SIZE-1:0]   w_sel_data;
    logic [KEEP_W-1:0]      w_sel_keep;
    logic [USER_SIZE-1:0]   w_sel_user;
    logic [SRC_W-1:0]       w_next_ptr;

    logic [DATA_SIZE-1:0]   w_data_arr [NUM_SRC];
    logic [KEEP_W-1:0]      w_keep_arr [NUM_SRC];
    logic [USER_SIZE-1:0]   w_user_arr [NUM_SRC];

    // Unpack the flat per-source payload buses.
    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_unpack
        assign w_data_arr[gi] = s_tdata[gi*DATA_SIZE +: DATA_SIZE];
        assign w_keep_arr[gi] = s_tkeep[gi*KEEP_W +: KEEP_W];
        assign w_user_arr[gi] = s_tuser[gi*USER_SIZE +: USER_SIZE];
    end

    axis_rr_pick #(
        .NUM_SRC (NUM_SRC),
        .SRC_W   (SRC_W)
    ) u_pick (
        .req (s_tvalid),
        .ptr (r_rr_ptr),
        .idx (w_pick_idx),
        .any (w_pick_any)
    );

    // Only the granted source sees ready, and only while the output slot can take a beat.
    always_comb begin
        w_s_tready = '0;
        if (r_state == GRANT) begin
            w_s_tready[r_grant_idx] = !r_m_tvalid || m_tready;
        end
    end

    assign w_accept   = |(s_tvalid & w_s_tready);
    assign w_sel_last = s_tlast[r_grant_idx];
    assign w_sel_data = w_data_arr[r_grant_idx];
    assign w_sel_keep = w_keep_arr[r_grant_idx];
    assign w_sel_user = w_user_arr[r_grant_idx];
    assign w_next_ptr = (r_grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : r_grant_idx + 1'b1;

    // Arbitration FSM plus the single output register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_m_tvalid  <= 1'b0;
            r_m_tlast   <= 1'b0;
            r_m_tdata   <= '0;
            r_m_tkeep   <= '0;
            r_m_tuser   <= '0;
            r_m_tid     <= '0;
        end else begin
            // Drain first; a beat loaded below in the same cycle overrides it.
            if (m_tready) begin
                r_m_tvalid <= 1'b0;
            end
            case (r_state)
                IDLE: begin
                    if (w_pick_any) begin
                        r_grant_idx <= w_pick_idx;
                        r_state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_accept) begin
                        r_m_tvalid <= 1'b1;
                        r_m_tlast  <= w_sel_last;
                        r_m_tdata  <= w_sel_data;
                        r_m_tkeep  <= w_sel_keep;
                        r_m_tuser  <= w_sel_user;
                        r_m_tid    <= r_grant_idx;
                        if (w_sel_last) begin
                            r_rr_ptr <= w_next_ptr;
                            r_state  <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign s_tready = w_s_tready;
    assign m_tvalid = r_m_tvalid;
    assign m_tlast  = r_m_tlast;
    assign m_tdata  = r_m_tdata;
    assign m_tkeep  = r_m_tkeep;
    assign m_tuser  = r_m_tuser;
    assign m_tid    = r_m_tid;
    assign busy     = (r_state == GRANT);

endmodule

// File: tb/tb_axis_pkt_arbiter.sv
// Directed bench for the packet arbiter with a per-source producer model and beat scoreboard.
// Latency: n/a.
// Backpressure: m_tready driven from per-cycle tables.
module tb_axis_pkt_arbiter;

    localparam int NS = 4;
    localparam int DW = 32;
    localparam int UW = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic [NS-1:0]  s_tvalid;
    logic [NS-1:0]  s_tready;
    logic [NS-1:0]  s_tlast;
    logic [NS*DW-1:0] s_tdata;
    logic [NS*4-1:0]  s_tkeep;
    logic [NS*UW-1:0] s_tuser;
    logic           m_tvalid;
    logic           m_tlast;
    logic           m_tready;
    logic [DW-1:0]  m_tdata;
    logic [3:0]     m_tkeep;
    logic [UW-1:0]  m_tuser;
    logic [1:0]     m_tid;
    logic           busy;

    int vecs = 0;
    int errs = 0;

    // Producer model state per source.
    int base     [NS];
    int plen     [NS];
    int pkt_left [NS];
    int beat     [NS];
    int pkt_no   [NS];
    logic [NS-1:0] gap;
    logic [NS-1:0] acc;

    typedef struct packed {
        logic [1:0]  tid;
        logic        last;
        logic [31:0] data;
    } beat_t;

    beat_t exp_q[$];

    // Hand-derived per-cycle expectations.
    logic [3:0] t1_rdy [6]  = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h0, 4'h0};
    logic       t1_vld [6]  = '{0, 0, 1, 1, 1, 0};
    logic       t1_bsy [6]  = '{0, 1, 1, 1, 0, 0};
    logic [3:0] t3_rdy [10] = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0, 4'h0};
    logic       t3_vld [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
    logic [3:0] t4_rdy [13] = '{4'h0, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8, 4'h8,
                                4'h0, 4'h1, 4'h1, 4'h0};
    logic       t4_bsy [13] = '{0, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1, 1, 0};
    logic [3:0] t6_rdy [5]  = '{4'h0, 4'h2, 4'h0, 4'h8, 4'h0};
    logic       t6_bsy [5]  = '{0, 1, 0, 1, 0};

    axis_pkt_arbiter #(
        .NUM_SRC   (NS),
        .DATA_SIZE (DW),
        .USER_SIZE (UW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .s_tvalid (s_tvalid),
        .s_tready (s_tready),
        .s_tlast  (s_tlast),
        .s_tdata  (s_tdata),
        .s_tkeep  (s_tkeep),
        .s_tuser  (s_tuser),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tuser  (m_tuser),
        .m_tid    (m_tid),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_srcs();
        for (int i = 0; i < NS; i++) begin
            base[i]     = 32'hC000 + i * 256;
            plen[i]     = 1;
            pkt_left[i] = 0;
            beat[i]     = 0;
            pkt_no[i]   = 0;
        end
        gap = '0;
    endtask

    task automatic expb(input logic [1:0] tid, input logic last, input logic [31:0] data);
        beat_t e;
        e.tid  = tid;
        e.last = last;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Drive every source from the model, then let combinational ready settle.
    task automatic pre();
        for (int i = 0; i < NS; i++) begin
            logic [31:0] d;
            d = 32'(base[i] + pkt_no[i] * 16 + beat[i]);
            s_tvalid[i]           = (pkt_left[i] > 0) && !gap[i];
            s_tlast[i]            = (beat[i] == plen[i] - 1);
            s_tdata[i*DW +: DW]   = d;
            s_tkeep[i*4 +: 4]     = d[3:0];
            s_tuser[i*UW +: UW]   = d[15:0] ^ 16'h5A5A;
        end
        #1;
        acc = s_tvalid & s_tready;
    endtask

    // Score the output transfer of this cycle, clock, then advance accepted sources.
    task automatic post();
        if (m_tvalid && m_tready) begin
            if (exp_q.size() == 0) begin
                chk("extra_beat", 64'(m_tvalid), 64'd0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat", 64'({m_tid, m_tlast, m_tdata, m_tkeep, m_tuser}),
                    64'({e.tid, e.last, e.data, e.data[3:0], e.data[15:0] ^ 16'h5A5A}));
            end
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < NS; i++) begin
            if (acc[i]) begin
                if (beat[i] == plen[i] - 1) begin
                    beat[i] = 0;
                    pkt_no[i]++;
                    pkt_left[i]--;
                end else begin
                    beat[i]++;
                end
            end
        end
    endtask

    initial begin
        clear_srcs();
        m_tready = 1'b1;
        s_tvalid = '0;
        s_tlast  = '0;
        s_tdata  = '0;
        s_tkeep  = '0;
        s_tuser  = '0;
        acc      = '0;

        // Reset state.
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_m", 64'({m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tid}), 64'd0);
        chk("rst_rdy", 64'(s_tready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;

        // All four sources, 2-beat packets: grant order 0,1,2,3,0.
        for (int i = 0; i < NS; i++) begin
            plen[i]     = 2;
            pkt_left[i] = (i == 0) ? 2 : 1;
        end
        expb(2'd0, 1'b0, 32'hC000); expb(2'd0, 1'b1, 32'hC001);
        expb(2'd1, 1'b0, 32'hC100); expb(2'd1, 1'b1, 32'hC101);
        expb(2'd2, 1'b0, 32'hC200); expb(2'd2, 1'b1, 32'hC201);
        expb(2'd3, 1'b0, 32'hC300); expb(2'd3, 1'b1, 32'hC301);
        expb(2'd0, 1'b0, 32'hC010); expb(2'd0, 1'b1, 32'hC011);
        for (int k = 0; k < 60 && exp_q.size() > 0; k++) begin
            pre();
            post();
        end
        chk("t2_drain", 64'(exp_q.size()), 64'd0);

        // Single source 2, 3-beat packet A0..A2.
        clear_srcs();
        base[2] = 32'hA0; plen[2] = 3; pkt_left[2] = 1;
        expb(2'd2, 1'b0, 32'hA0); expb(2'd2, 1'b0, 32'hA1); expb(2'd2, 1'b1, 32'hA2);
        for (int c = 0; c < 6; c++) begin
            pre();
            chk("t1_rdy", 64'(s_tready), 64'(t1_rdy[c]));
            chk("t1_vld", 64'(m_tvalid), 64'(t1_vld[c]));
            chk("t1_busy", 64'(busy), 64'(t1_bsy[c]));
            post();
        end
        chk("t1_drain", 64'(exp_q.size()), 64'd0);

        // Source 1, 4 beats, m_tready low in cycles 2..4.
        clear_srcs();
        plen[1] = 4; pkt_left[1] = 1;
        expb(2'd1, 1'b0, 32'hC100); expb(2'd1, 1'b0, 32'hC101);
        expb(2'd1, 1'b0, 32'hC102); expb(2'd1, 1'b1, 32'hC103);
        for (int c = 0; c < 10; c++) begin
            m_tready = !(c >= 2 && c <= 4);
            pre();
            chk("t3_rdy", 64'(s_tready), 64'(t3_rdy[c]));
            chk("t3_vld", 64'(m_tvalid), 64'(t3_vld[c]));
            if (c >= 2 && c <= 4) begin
                chk("t3_hold", 64'({m_tid, m_tdata}), 64'({2'd1, 32'hC100}));
            end
            post();
        end
        m_tready = 1'b1;
        chk("t3_drain", 64'(exp_q.size()), 64'd0);

        // Source 3 stalls 5 cycles mid-packet while source 0 requests.
        clear_srcs();
        plen[3] = 3; pkt_left[3] = 1;
        plen[0] = 2; pkt_left[0] = 1;
        expb(2'd3, 1'b0, 32'hC300); expb(2'd3, 1'b0, 32'hC301); expb(2'd3, 1'b1, 32'hC302);
        expb(2'd0, 1'b0, 32'hC000); expb(2'd0, 1'b1, 32'hC001);
        for (int c = 0; c < 13; c++) begin
            gap[3] = (c >= 3 && c <= 7);
            pre();
            chk("t4_rdy", 64'(s_tready), 64'(t4_rdy[c]));
            chk("t4_busy", 64'(busy), 64'(t4_bsy[c]));
            post();
        end
        chk("t4_drain", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset while the second beat of a source-2 packet is on the output.
        clear_srcs();
        plen[2] = 3; pkt_left[2] = 1;
        expb(2'd2, 1'b0, 32'hC200);
        for (int c = 0; c < 3; c++) begin
            pre();
            post();
        end
        pre();
        chk("t5_pre", 64'({m_tvalid, m_tid, m_tdata}), 64'({1'b1, 2'd2, 32'hC201}));
        reset = 1'b1;
        #1;
        chk("t5_async_m", 64'({m_tvalid, m_tlast, m_tdata, m_tkeep, m_tuser, m_tid}), 64'd0);
        chk("t5_async_rdy", 64'(s_tready), 64'd0);
        chk("t5_async_busy", 64'(busy), 64'd0);
        clear_srcs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        pkt_left[0] = 1; pkt_left[1] = 1; pkt_left[2] = 1;
        pre();
        chk("t5_idle_rdy", 64'(s_tready), 64'd0);
        post();
        pre();
        chk("t5_lowest", 64'(s_tready), 64'h1);
        reset = 1'b1;
        clear_srcs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_drain", 64'(exp_q.size()), 64'd0);

        // Single-beat packets from sources 1 and 3 together, rr_ptr at 0.
        clear_srcs();
        pkt_left[1] = 1; pkt_left[3] = 1;
        expb(2'd1, 1'b1, 32'hC100); expb(2'd3, 1'b1, 32'hC300);
        for (int c = 0; c < 5; c++) begin
            pre();
            chk("t6_rdy", 64'(s_tready), 64'(t6_rdy[c]));
            chk("t6_busy", 64'(busy), 64'(t6_bsy[c]));
            post();
        end
        chk("t6_drain", 64'(exp_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
